// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake with a one-entry skid buffer,
// stall hold, flush-to-NOP and saturating stall/flush event counters.
module ifid_pipe_reg #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o,
    input  logic              ready_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              main_valid_reg, main_valid_next;
    logic [PC_W-1:0]   main_pc_reg, main_pc_next;
    logic [INST_W-1:0] main_inst_reg, main_inst_next;
    logic              skid_valid_reg, skid_valid_next;
    logic [PC_W-1:0]   skid_pc_reg, skid_pc_next;
    logic [INST_W-1:0] skid_inst_reg, skid_inst_next;
    logic              ready_reg, ready_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;
    logic [CNT_W-1:0]  flush_cnt_reg, flush_cnt_next;

    logic accept;
    logic drain;
    logic stall_event;
    logic flush_event;

    assign accept      = valid_i & ready_reg;
    assign drain       = main_valid_reg & ready_i & ~stall_i;
    assign stall_event = main_valid_reg & (stall_i | ~ready_i) & ~flush_i;
    assign flush_event = flush_i & (main_valid_reg | skid_valid_reg);

    // The three occupancy states (EMPTY/ONE/FULL) are encoded directly by the
    // two valid bits; payloads are zeroed whenever their entry empties.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_pc_next    = main_pc_reg;
        main_inst_next  = main_inst_reg;
        skid_valid_next = skid_valid_reg;
        skid_pc_next    = skid_pc_reg;
        skid_inst_next  = skid_inst_reg;

        if (flush_i) begin
            main_valid_next = 1'b0;
            main_pc_next    = '0;
            main_inst_next  = '0;
            skid_valid_next = 1'b0;
            skid_pc_next    = '0;
            skid_inst_next  = '0;
        end else if (!main_valid_reg) begin
            if (accept) begin
                main_valid_next = 1'b1;
                main_pc_next    = pc_i;
                main_inst_next  = inst_i;
            end
        end else if (!skid_valid_reg) begin
            if (accept && drain) begin
                main_pc_next   = pc_i;
                main_inst_next = inst_i;
            end else if (accept) begin
                skid_valid_next = 1'b1;
                skid_pc_next    = pc_i;
                skid_inst_next  = inst_i;
            end else if (drain) begin
                main_valid_next = 1'b0;
                main_pc_next    = '0;
                main_inst_next  = '0;
            end
        end else if (drain) begin
            main_pc_next    = skid_pc_reg;
            main_inst_next  = skid_inst_reg;
            skid_valid_next = 1'b0;
            skid_pc_next    = '0;
            skid_inst_next  = '0;
        end
    end

    // ready_o is registered from the next occupancy, so it never depends
    // combinationally on ready_i or stall_i.
    assign ready_next = ~skid_valid_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall_event && stall_cnt_reg != CNT_MAX) begin
            stall_cnt_next = stall_cnt_reg + CNT_ONE;
        end
        if (flush_event && flush_cnt_reg != CNT_MAX) begin
            flush_cnt_next = flush_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_reg <= 1'b0;
            main_pc_reg    <= '0;
            main_inst_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_pc_reg    <= '0;
            skid_inst_reg  <= '0;
            ready_reg      <= 1'b1;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            main_pc_reg    <= main_pc_next;
            main_inst_reg  <= main_inst_next;
            skid_valid_reg <= skid_valid_next;
            skid_pc_reg    <= skid_pc_next;
            skid_inst_reg  <= skid_inst_next;
            ready_reg      <= ready_next;
            stall_cnt_reg  <= stall_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign ready_o     = ready_reg;
    assign valid_o     = main_valid_reg;
    assign pc_o        = main_pc_reg;
    assign inst_o      = main_inst_reg;
    assign stall_cnt_o = stall_cnt_reg;
    assign flush_cnt_o = flush_cnt_reg;

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Bench for ifid_pipe_reg: a queue-based occupancy model drives expectations for
// a wide-counter instance and a 2-bit-counter instance fed the same stimulus.
module tb_ifid_pipe_reg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic [PC_W-1:0]   pc_in = '0;
    logic [INST_W-1:0] inst_in = '0;
    logic              ready_in = 1'b0;
    logic              stall_in = 1'b0;
    logic              flush_in = 1'b0;

    logic              ready_w, valid_w;
    logic [PC_W-1:0]   pc_w;
    logic [INST_W-1:0] inst_w;
    logic [15:0]       stall_cnt_w, flush_cnt_w;

    logic              ready_s, valid_s;
    logic [PC_W-1:0]   pc_s;
    logic [INST_W-1:0] inst_s;
    logic [1:0]        stall_cnt_s, flush_cnt_s;

    always #5 clk = ~clk;

    ifid_pipe_reg #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .pc_i(pc_in), .inst_i(inst_in),
        .ready_o(ready_w), .valid_o(valid_w), .pc_o(pc_w), .inst_o(inst_w),
        .ready_i(ready_in), .stall_i(stall_in), .flush_i(flush_in),
        .stall_cnt_o(stall_cnt_w), .flush_cnt_o(flush_cnt_w)
    );

    ifid_pipe_reg #(.PC_W(PC_W), .INST_W(INST_W), .CNT_W(2)) dut_small (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_in), .pc_i(pc_in), .inst_i(inst_in),
        .ready_o(ready_s), .valid_o(valid_s), .pc_o(pc_s), .inst_o(inst_s),
        .ready_i(ready_in), .stall_i(stall_in), .flush_i(flush_in),
        .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
    );

    typedef struct {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } beat_t;

    beat_t q[$];
    int unsigned m_stall, m_flush, m_stall_s, m_flush_s;
    int total = 0;
    int bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    endtask

    // One clock of the reference: a FIFO of at most two beats, head visible to decode.
    task automatic model_clock();
        bit acc, drn;
        acc = valid_in && (q.size() < 2);
        drn = (q.size() > 0) && ready_in && !stall_in;
        if (q.size() > 0 && (stall_in || !ready_in) && !flush_in) begin
            m_stall   = sat_inc(m_stall, 65535);
            m_stall_s = sat_inc(m_stall_s, 3);
        end
        if (flush_in && q.size() > 0) begin
            m_flush   = sat_inc(m_flush, 65535);
            m_flush_s = sat_inc(m_flush_s, 3);
        end
        if (drn) $display("beat to decode pc=%08h inst=%08h%s", q[0].pc, q[0].inst,
                          flush_in ? " (flush)" : "");
        if (flush_in) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc_in, inst: inst_in});
        end
    endtask

    task automatic compare_all();
        logic [PC_W-1:0]   e_pc;
        logic [INST_W-1:0] e_inst;
        e_pc   = (q.size() > 0) ? q[0].pc : '0;
        e_inst = (q.size() > 0) ? q[0].inst : '0;
        check_val("valid", valid_w, (q.size() > 0));
        check_val("pc", pc_w, e_pc);
        check_val("inst", inst_w, e_inst);
        check_val("ready", ready_w, (q.size() < 2));
        check_val("stall_cnt", stall_cnt_w, m_stall);
        check_val("flush_cnt", flush_cnt_w, m_flush);
        check_val("s_valid", valid_s, (q.size() > 0));
        check_val("s_pc", pc_s, e_pc);
        check_val("s_inst", inst_s, e_inst);
        check_val("s_ready", ready_s, (q.size() < 2));
        check_val("s_stall_cnt", stall_cnt_s, m_stall_s);
        check_val("s_flush_cnt", flush_cnt_s, m_flush_s);
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit stl, input bit fl);
        valid_in = v;
        pc_in    = pc;
        inst_in  = 32'h0013_0000 ^ (pc << 4) ^ 32'h93;
        ready_in = rdy;
        stall_in = stl;
        flush_in = fl;
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_valid"}, valid_w, 0);
        check_val({tag, "_pc"}, pc_w, 0);
        check_val({tag, "_inst"}, inst_w, 0);
        check_val({tag, "_ready"}, ready_w, 1);
        check_val({tag, "_stall_cnt"}, stall_cnt_w, 0);
        check_val({tag, "_flush_cnt"}, flush_cnt_w, 0);
        check_val({tag, "_s_valid"}, valid_s, 0);
        check_val({tag, "_s_stall_cnt"}, stall_cnt_s, 0);
    endtask

    initial begin
        model_reset();
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b0;

        // In-order streaming at full rate.
        drive(1, 32'h0, 1, 0, 0); step(); check_val("seq_pc0", pc_w, 32'h0);
        drive(1, 32'h4, 1, 0, 0); step(); check_val("seq_pc4", pc_w, 32'h4);
        drive(1, 32'h8, 1, 0, 0); step(); check_val("seq_pc8", pc_w, 32'h8);
        check_val("seq_ready", ready_w, 1);
        drive(0, 0, 1, 0, 0); step();

        // Back-pressure into the skid entry, then release.
        drive(1, 32'h10, 1, 0, 0); step();
        drive(1, 32'h14, 0, 0, 0); step();
        check_val("skid_ready_low", ready_w, 0);
        check_val("skid_pc_hold", pc_w, 32'h10);
        drive(0, 0, 1, 0, 0); step();
        check_val("skid_pc_next", pc_w, 32'h14);
        check_val("skid_ready_back", ready_w, 1);
        step();

        // Stall freezes the output for three cycles.
        drive(1, 32'h18, 1, 0, 0); step();
        drive(0, 0, 1, 1, 0);
        repeat (3) begin
            step();
            check_val("stall_pc_frozen", pc_w, 32'h18);
        end
        drive(0, 0, 1, 0, 0); step();

        // Flush while FULL, with a beat offered in the same cycle.
        drive(1, 32'h20, 1, 0, 0); step();
        drive(1, 32'h24, 0, 0, 0); step();
        check_val("full_ready", ready_w, 0);
        drive(1, 32'h28, 0, 0, 1); step();
        check_val("flush_valid", valid_w, 0);
        check_val("flush_inst", inst_w, 0);
        drive(0, 0, 1, 0, 0); repeat (2) step();

        // Flush with nothing held.
        drive(0, 0, 1, 0, 1); step();
        drive(0, 0, 1, 0, 0); step();

        // Long stall drives the 2-bit counter to saturation.
        drive(1, 32'h30, 1, 0, 0); step();
        drive(0, 0, 1, 1, 0); repeat (5) step();
        check_val("sat_small", stall_cnt_s, 2'd3);
        drive(0, 0, 1, 0, 0); step();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 49) < 2);
            inst_in = $urandom;
            step();
        end

        // Asynchronous reset between edges while FULL.
        drive(1, 32'h40, 0, 0, 0); step();
        drive(1, 32'h44, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 32'h50, 1, 0, 0); step();
        drive(0, 0, 1, 0, 0); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_reg.md
# ifid_pipe_reg

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer, a stall input, a flush input and saturating event counters. It sits between the fetch stage and the decode stage. It carries a program counter and an instruction word, and supports back-pressure without losing a fetched instruction. Flush squashes everything in flight and presents a NOP (all-zero instruction) to decode.

## Interface
Parameters:
- PC_W, 32, width of program-counter field
- INST_W, 32, width of instruction field
- CNT_W, 16, width of each event counter

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high; clears all state
- valid_i  in  1  upstream beat valid
- pc_i  in  PC_W  upstream program counter
- inst_i  in  INST_W  upstream instruction
- ready_o  out  1  block can accept a beat this cycle (registered)
- valid_o  out  1  output beat valid
- pc_o  out  PC_W  program counter to decode
- inst_o  out  INST_W  instruction to decode; 0 (NOP) when not valid
- ready_i  in  1  decode can consume this cycle
- stall_i  in  1  hazard hold; when high, output is held regardless of ready_i
- flush_i  in  1  squash all contents
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and the output blocked
- flush_cnt_o  out  CNT_W  flush cycles that squashed at least one valid entry

## Operation
- Storage: main entry (drives pc_o/inst_o/valid_o) and skid entry (valid bit + payload).
- accept = valid_i & ready_o; drain = valid_o & ready_i & ~stall_i.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid). ready_o = 1 in EMPTY/ONE, 0 in FULL.
- EMPTY: accept -> ONE, main <= input.
- ONE:
  - accept & drain -> ONE, main <= input.
  - accept & ~drain -> FULL, skid <= input.
  - ~accept & drain -> EMPTY.
  - otherwise hold.
- FULL: drain -> ONE, main <= skid, skid cleared; otherwise hold.
- flush_i has priority over every other event. The next state is EMPTY. Main and skid payloads are zeroed and both valid bits cleared. A beat accepted in the same cycle is consumed from upstream and discarded. A drain in the same cycle still counts as taken by decode.
- Entering EMPTY by any path zeroes pc_o and inst_o, so inst_o=0 whenever valid_o=0.
- stall_cnt_o increments when valid_o & (stall_i | ~ready_i) and flush_i=0.
- flush_cnt_o increments when flush_i & (main valid | skid valid).
- Both counters saturate at 2^CNT_W-1 and are cleared only by rst_i.

## Timing
- Reset values: valid_o=0, pc_o=0, inst_o=0, ready_o=1, stall_cnt_o=0, flush_cnt_o=0, state EMPTY. Reset takes effect immediately, without waiting for a clock edge, including mid-transfer; all in-flight beats are lost.
- Latency: a beat accepted at edge N appears on valid_o/pc_o/inst_o after edge N (one cycle).
- Throughput: one beat per cycle while ready_i=1 and stall_i=0.
- ready_o is a register output with no combinational path from ready_i or stall_i. Upstream may see ready_o=1 for one cycle after decode blocks; the skid entry absorbs that beat.
- Order is preserved: the skid beat is always delivered before any later beat.
- Payload is stable while valid_o=1 and the output is not drained.

## Test plan
- Reset, then valid_i=1 with pc_i=0x0, 0x4, 0x8 on consecutive cycles, ready_i=1 -> valid_o=1 one cycle later each, pc_o=0x0, 0x4, 0x8 in order, ready_o stays 1.
- Main holds pc 0x10. Drive ready_i=0 while offering pc 0x14 -> 0x14 goes to skid, ready_o=0 next cycle, pc_o stays 0x10. Raise ready_i -> pc_o=0x10 then 0x14, ready_o returns to 1.
- stall_i=1 for 3 cycles with valid_o=1, ready_i=1 -> pc_o/inst_o frozen, stall_cnt_o rises by 3.
- In FULL state assert flush_i with valid_i=1 -> next cycle valid_o=0, inst_o=0, pc_o=0, ready_o=1, flush_cnt_o+1. The offered beat never appears on the output.
- flush_i while EMPTY -> flush_cnt_o unchanged, outputs remain 0.
- CNT_W=2, hold stall for 5 cycles -> stall_cnt_o saturates at 3. Assert rst_i mid-stream between clock edges -> all outputs at reset values immediately.
